// File: rtl/aes_pkg.sv
// aes_pkg: constants, sequencer state encoding and key-size helpers
// shared by the serial AES controller and its shift-register datapath.
package aes_pkg;

  localparam int AES_BLOCK_BITS   = 128;
  localparam int AES_KEY_MAX_BITS = 256;
  // Bit counter width: covers 128 data bits plus up to 256 key bits.
  localparam int AES_CNT_BITS     = 9;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    LOAD,
    GAP,
    WAIT,
    READ,
    DONE
  } aes_state_t;

  // Key length in bits for a key of nk 32-bit words.
  function automatic int aes_key_bits(input int nk);
    return 32 * nk;
  endfunction

  // Only AES-128/192/256 key sizes are supported by the cores.
  function automatic bit aes_nk_legal(input int nk);
    return (nk == 4) || (nk == 6) || (nk == 8);
  endfunction

endpackage

// File: rtl/aes_shift_io.sv
// aes_shift_io: serial datapath of the AES sequencer.
// A parallel-load PISO holds {key, data} and presents its LSB as the next
// serial bit; a SIPO assembles the result LSB first. The SIPO keeps only
// 127 bits because the final bit is taken straight from rx_bit when the
// controller loads the completed word.
module aes_shift_io
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [AES_BLOCK_BITS-1:0] load_data,
  input  logic [KEY_BITS-1:0]       load_key,
  input  logic                      shift,
  output logic                      tx_bit,
  input  logic                      capture,
  input  logic                      rx_bit,
  output logic [AES_BLOCK_BITS-1:0] rx_next
);

  localparam int TX_BITS = AES_BLOCK_BITS + KEY_BITS;

  logic [TX_BITS-1:0]        tx_q;
  logic [AES_BLOCK_BITS-2:0] rx_q;

  assign tx_bit  = tx_q[0];
  assign rx_next = {rx_bit, rx_q};

  // Transmit register: capture data||key on accept, shift right per sent bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_q <= '0;
    end else if (load) begin
      tx_q <= {load_key, load_data};
    end else if (shift) begin
      tx_q <= {1'b0, tx_q[TX_BITS-1:1]};
    end
  end

  // Receive register: newest bit enters at the top, so the first bit ends at bit 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q <= '0;
    end else if (capture) begin
      rx_q <= rx_next[AES_BLOCK_BITS-1:1];
    end
  end

endmodule

// File: rtl/aes_serial_ctrl.sv
// aes_serial_ctrl: valid/ready front end for the bit-serial AES cores.
// Loads one block and key into the core over cs/miso, pulses cs low to
// start the computation, then reads the 128-bit result back over mosi.
// Optional feature macro: AES_CTRL_DECRYPT_EN adds a second (decrypt) core
// port set and an in_mode select captured with each request.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a request, cs low
// PRE   | one cycle of cs high with miso=0 ahead of the first bit
// LOAD  | shift 128 data bits then KEY_BITS key bits, LSB first
// GAP   | one cycle of cs low: restart pulse, core starts computing
// WAIT  | CORE_WAIT cycles of cs high before the first result bit
// READ  | sample 128 result bits from mosi, LSB first
// DONE  | result held on out_data with out_valid=1 until out_ready
module aes_serial_ctrl
  import aes_pkg::*;
#(
  parameter int NK        = 4,
  parameter int CORE_WAIT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [AES_BLOCK_BITS-1:0]   in_data,
  input  logic [AES_KEY_MAX_BITS-1:0] in_key,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [AES_BLOCK_BITS-1:0]   out_data,
  output logic                        core_cs,
  output logic                        core_miso,
  input  logic                        core_mosi
`ifdef AES_CTRL_DECRYPT_EN
  ,
  input  logic                        in_mode,
  output logic                        dcore_cs,
  output logic                        dcore_miso,
  input  logic                        dcore_mosi
`endif
);

  localparam int KEY_BITS = aes_key_bits(NK);
  localparam logic [AES_CNT_BITS-1:0] LOAD_LAST =
    AES_CNT_BITS'(AES_BLOCK_BITS + KEY_BITS - 1);
  localparam logic [AES_CNT_BITS-1:0] READ_LAST =
    AES_CNT_BITS'(AES_BLOCK_BITS - 1);
  localparam int WAIT_W = (CORE_WAIT > 1) ? $clog2(CORE_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CORE_WAIT - 1);

  if (!aes_nk_legal(NK)) begin : g_bad_nk
    $error("aes_serial_ctrl: NK must be 4, 6 or 8");
  end

  if (CORE_WAIT < 1) begin : g_bad_wait
    $error("aes_serial_ctrl: CORE_WAIT must be at least 1");
  end

  // Key bits above KEY_BITS never reach the core.
  if (KEY_BITS < AES_KEY_MAX_BITS) begin : g_key_trim
    logic unused_key_hi;
    assign unused_key_hi = ^in_key[AES_KEY_MAX_BITS-1:KEY_BITS];
  end

  aes_state_t              state;
  logic [AES_CNT_BITS-1:0] bit_cnt;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    seq_cs;
  logic                    seq_miso;

  logic                      accept;
  logic                      tx_shift;
  logic                      rx_capture;
  logic                      tx_bit;
  logic                      rx_bit;
  logic [AES_BLOCK_BITS-1:0] rx_next;

  assign accept     = (state == IDLE) && in_valid;
  // The bit sent in PRE's successor and every LOAD cycle but the last is
  // pulled from the PISO at the edge that starts that cycle.
  assign tx_shift   = (state == PRE) || ((state == LOAD) && (bit_cnt != LOAD_LAST));
  assign rx_capture = (state == READ);

`ifdef AES_CTRL_DECRYPT_EN
  logic mode_q;

  // Core select is fixed for the whole transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
    end else if (accept) begin
      mode_q <= in_mode;
    end
  end

  assign rx_bit     = mode_q ? dcore_mosi : core_mosi;
  assign core_cs    = seq_cs   & ~mode_q;
  assign core_miso  = seq_miso & ~mode_q;
  assign dcore_cs   = seq_cs   &  mode_q;
  assign dcore_miso = seq_miso &  mode_q;
`else
  assign rx_bit    = core_mosi;
  assign core_cs   = seq_cs;
  assign core_miso = seq_miso;
`endif

  aes_shift_io #(
    .KEY_BITS (KEY_BITS)
  ) u_shift_io (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (in_data),
    .load_key  (in_key[KEY_BITS-1:0]),
    .shift     (tx_shift),
    .tx_bit    (tx_bit),
    .capture   (rx_capture),
    .rx_bit    (rx_bit),
    .rx_next   (rx_next)
  );

  // Sequencer: state, bit/wait counters and registered handshake and serial outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      seq_cs    <= 1'b0;
      seq_miso  <= 1'b0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= PRE;
            in_ready <= 1'b0;
            seq_cs   <= 1'b1;
            seq_miso <= 1'b0;
          end
        end
        PRE: begin
          state    <= LOAD;
          bit_cnt  <= '0;
          seq_miso <= tx_bit;
        end
        LOAD: begin
          if (bit_cnt == LOAD_LAST) begin
            state    <= GAP;
            seq_cs   <= 1'b0;
            seq_miso <= 1'b0;
          end else begin
            bit_cnt  <= bit_cnt + 1'b1;
            seq_miso <= tx_bit;
          end
        end
        GAP: begin
          state    <= WAIT;
          seq_cs   <= 1'b1;
          wait_cnt <= WAIT_LOAD;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state   <= READ;
            bit_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        READ: begin
          if (bit_cnt == READ_LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= rx_next;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            seq_cs    <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          seq_cs    <= 1'b0;
          seq_miso  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_serial_ctrl.md
Name: aes_serial_ctrl

Overview:
- Sequencer sitting between a parallel valid/ready requester and the bit-serial AES core (cs/miso/mosi interface, same as the Encrypt and Decrypt modules).
- Accepts one 128-bit block plus key and shifts both into the core.
- Pulses cs to start the computation, then shifts the 128-bit result back out and presents it in parallel.
- Replaces hand-sequenced serial stimulus, so the cores can sit behind any bus master.

Parameters:
- NK, 4, key length in 32-bit words (4/6/8); must match the core's Nk. KEY_BITS = 32*NK.
- CORE_WAIT, 1, cycles cs is held high after the restart pulse before the first result bit is sampled (minimum 1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  controller idle; a request is accepted when in_valid & in_ready.
- in_data  in  128  plaintext (or ciphertext in decrypt mode).
- in_key  in  256  key; only bits [KEY_BITS-1:0] are used.
- out_valid  out  1  result held and valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  128  result block.
- core_cs  out  1  chip select to the encrypt core.
- core_miso  out  1  serial data to the encrypt core.
- core_mosi  in  1  serial data from the encrypt core.

Behaviour:
- Reset (async, immediate): state IDLE. in_ready=1, out_valid=0, out_data=0, core_cs=0, core_miso=0. Bit counter and wait counter cleared. Captured data and key cleared.
- Reset mid-operation aborts the transaction; no partial result is ever presented.
- IDLE: core_cs=0, in_ready=1. On accept, register in_data and in_key (later input changes are ignored), drop in_ready, go to PRE.
- PRE (1 cycle): core_cs=1, core_miso=0. Go to LOAD with bit counter k=0.
- LOAD (128+KEY_BITS cycles): core_cs=1.
  - Cycle k drives core_miso = data[k] for k<128, otherwise key[k-128]. LSB first for both.
  - core_miso is registered, so each bit is stable for exactly one full cycle.
  - After the last key bit, go to GAP.
- GAP (1 cycle): core_cs=0, core_miso=0. This is the restart pulse that starts the core computing. Go to WAIT.
- WAIT (CORE_WAIT cycles): core_cs=1. Then go to READ with k=0.
- READ (128 cycles): core_cs=1. At the rising edge ending cycle k, result[k] <= core_mosi (LSB first). After k=127, go to DONE.
- DONE: core_cs=1, out_valid=1, out_data stable.
  - On out_valid & out_ready, go to IDLE: out_valid=0 and core_cs=0 on the next cycle.
  - out_data keeps its last value until the next result is loaded.
- Latency from accept to out_valid: 1 + (128+KEY_BITS) + 1 + CORE_WAIT + 128 cycles. This is 387 cycles for NK=4, CORE_WAIT=1.
- in_ready is 1 only in IDLE. A request arriving in the same cycle as the out handshake is accepted one cycle later (no overlap).
- in_valid deasserting after accept has no effect.
- out_ready asserted while out_valid=0 is ignored.
- Counter: 9 bits, sized for 128+256. It never wraps within a legal transaction and is compared against exact terminal counts.
- Illegal NK (not 4/6/8): elaboration error.

Optional Feature:
- Macro: AES_CTRL_DECRYPT_EN.
- Defined:
  - Extra ports: in_mode (in, 1; 0=encrypt, 1=decrypt), dcore_cs (out), dcore_miso (out), dcore_mosi (in).
  - in_mode is captured on accept. The sequence runs on the selected core only; the other core sees cs=0 and miso=0 throughout.
  - READ samples the selected core's mosi.
- Not defined: none of these ports exist and every request is an encryption.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_BITS=128, AES_KEY_MAX_BITS=256.
  - State encoding typedef: IDLE, PRE, LOAD, GAP, WAIT, READ, DONE.
  - Helper for KEY_BITS from NK.
- Sub-module aes_shift_io holds the two shift registers:
  - parallel-load PISO for data||key, driving miso;
  - SIPO for the result, capturing mosi.
- The FSM and counters stay in aes_serial_ctrl.

Test Plan:
- FIPS-197 AES-128 (NK=4, encrypt core instantiated): in_data=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f.
  - Required: out_data=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 387 cycles after accept.
  - Required: core_cs low for exactly 1 cycle between LOAD and WAIT.
- NK=6, same in_data, key 000102…1617 -> out_data=dda97ca4864cdfe06eaf70a0ec0d7191. NK=8, key 000102…1e1f -> 8ea2b7ca516745bfeafc49904b496089.
- Backpressure: hold out_ready=0 for 50 cycles with in_valid=1 and new data applied.
  - Required: in_ready=0 and out_data unchanged throughout.
  - Required: after the out handshake, the new request is accepted one cycle later and yields the correct result.
- Assert rst at LOAD bit 100.
  - Required: the same cycle shows core_cs=0, out_valid=0, in_ready=1.
  - Required: the next full request produces 69c4e0d86a7b0430d8cdb78070b4c55a.
- With AES_CTRL_DECRYPT_EN: in_mode=1, in_data=69c4e0d86a7b0430d8cdb78070b4c55a, key 000102…0f.
  - Required: out_data=00112233445566778899aabbccddeeff.
  - Required: core_cs=0 and core_miso=0 for the whole transaction.
